// File: rtl/muxn_scan.sv
// N-channel registered multiplexer with manual select and round-robin scan.
// out and cur_sel are registered together from the same next_sel, so they always agree.
module muxn_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_flat,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          control,
  input  logic                      enable,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      sel_changed,
  output logic                      sel_err
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [SEL_W-1:0] r_cur_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_sel_changed;
  logic             r_sel_err;

  logic [SEL_W-1:0] w_next_sel;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_err_next;
  logic [WIDTH-1:0] w_out_next;

  // Next selection and dwell count; illegal manual codes hold the current channel.
  always_comb begin
    w_next_sel = r_cur_sel;
    w_cnt_next = r_cnt;
    w_err_next = 1'b0;
    if (mode == 1'b0) begin
      w_cnt_next = {CNT_W{1'b0}};
      if (control <= MAX_SEL) begin
        w_next_sel = control;
      end else begin
        w_err_next = 1'b1;
      end
    end else begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_next = {CNT_W{1'b0}};
        if (r_cur_sel == MAX_SEL) begin
          w_next_sel = {SEL_W{1'b0}};
        end else begin
          w_next_sel = r_cur_sel + SEL_W'(1);
        end
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
  end

  // Data for the next selection; codes at or above CHANNELS never reach this point.
  always_comb begin
    w_out_next = {WIDTH{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_next_sel == SEL_W'(i)) begin
        w_out_next = in_flat[i*WIDTH +: WIDTH];
      end else begin
        w_out_next = w_out_next;
      end
    end
  end

  // State registers; pulses drop to zero on frozen edges so they stay single-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_sel     <= {SEL_W{1'b0}};
      r_cnt         <= {CNT_W{1'b0}};
      r_out         <= {WIDTH{1'b0}};
      r_sel_changed <= 1'b0;
      r_sel_err     <= 1'b0;
    end else if (enable) begin
      r_cur_sel     <= w_next_sel;
      r_cnt         <= w_cnt_next;
      r_out         <= w_out_next;
      r_sel_changed <= (w_next_sel != r_cur_sel);
      r_sel_err     <= w_err_next;
    end else begin
      r_sel_changed <= 1'b0;
      r_sel_err     <= 1'b0;
    end
  end

  assign out         = r_out;
  assign cur_sel     = r_cur_sel;
  assign sel_changed = r_sel_changed;
  assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_muxn_scan.sv
// Bench for muxn_scan: a 4-channel DWELL=3 instance and a 3-channel DWELL=2 instance
// driven together and compared against a per-instance behavioural model.
module tb_muxn_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mode = 1'b0;
  logic [1:0] control = 2'd0;
  logic       enable = 1'b1;
  logic [3:0] data_a [4];
  logic [3:0] data_b [3];
  logic [15:0] flat_a;
  logic [11:0] flat_b;

  logic [3:0] a_out, b_out;
  logic [1:0] a_sel, b_sel;
  logic       a_chg, b_chg, a_err, b_err;

  int tests = 0;
  int fails = 0;

  int         m_sel [2];
  int         m_cnt [2];
  logic [3:0] m_out [2];
  logic       m_chg [2];
  logic       m_err [2];

  assign flat_a = {data_a[3], data_a[2], data_a[1], data_a[0]};
  assign flat_b = {data_b[2], data_b[1], data_b[0]};

  always #5 clk = ~clk;

  muxn_scan #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_flat(flat_a), .mode(mode), .control(control),
    .enable(enable), .out(a_out), .cur_sel(a_sel), .sel_changed(a_chg), .sel_err(a_err)
  );

  muxn_scan #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_flat(flat_b), .mode(mode), .control(control),
    .enable(enable), .out(b_out), .cur_sel(b_sel), .sel_changed(b_chg), .sel_err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sel[d] = 0; m_cnt[d] = 0; m_out[d] = 4'd0; m_chg[d] = 1'b0; m_err[d] = 1'b0;
    end
  endtask

  // One enabled/frozen edge of the reference behaviour for instance d.
  task automatic model_step(input int d);
    int n, dw, ns;
    n  = (d == 0) ? 4 : 3;
    dw = (d == 0) ? 3 : 2;
    if (!rst_n) begin
      m_sel[d] = 0; m_cnt[d] = 0; m_out[d] = 4'd0; m_chg[d] = 1'b0; m_err[d] = 1'b0;
      return;
    end
    if (!enable) begin
      m_chg[d] = 1'b0; m_err[d] = 1'b0;
      return;
    end
    ns = m_sel[d];
    if (!mode) begin
      m_cnt[d] = 0;
      if (int'(control) < n) begin
        ns = int'(control); m_err[d] = 1'b0;
      end else begin
        m_err[d] = 1'b1;
      end
    end else begin
      m_err[d] = 1'b0;
      m_cnt[d] = m_cnt[d] + 1;
      if (m_cnt[d] == dw) begin
        m_cnt[d] = 0;
        ns = (m_sel[d] + 1) % n;
      end
    end
    m_chg[d] = (ns != m_sel[d]);
    m_sel[d] = ns;
    m_out[d] = (d == 0) ? data_a[ns] : data_b[ns];
  endtask

  task automatic check_all(input string where);
    chk({where, ".a.out"}, 32'(a_out), 32'(m_out[0]));
    chk({where, ".a.sel"}, 32'(a_sel), 32'(m_sel[0]));
    chk({where, ".a.chg"}, 32'(a_chg), 32'(m_chg[0]));
    chk({where, ".a.err"}, 32'(a_err), 32'(m_err[0]));
    chk({where, ".b.out"}, 32'(b_out), 32'(m_out[1]));
    chk({where, ".b.sel"}, 32'(b_sel), 32'(m_sel[1]));
    chk({where, ".b.chg"}, 32'(b_chg), 32'(m_chg[1]));
    chk({where, ".b.err"}, 32'(b_err), 32'(m_err[1]));
  endtask

  task automatic tick(input string where);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all(where);
  endtask

  task automatic async_reset(input string where);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(where);
  endtask

  initial begin
    int budget;
    data_a[0] = 4'b0101; data_a[1] = 4'b0000; data_a[2] = 4'b1111; data_a[3] = 4'b0011;
    data_b[0] = 4'b1010; data_b[1] = 4'b0110; data_b[2] = 4'b1001;
    model_reset();

    // Reset asserted before any clock edge, then held across edges.
    #1 rst_n = 1'b0;
    #1 check_all("rst_async");
    for (int i = 0; i < 3; i++) tick("rst_hold");
    rst_n = 1'b1;

    // Manual select sweep, including code 3 (illegal for the 3-channel instance).
    for (int c = 0; c < 5; c++) begin
      control = (c == 4) ? 2'd0 : 2'(c);
      for (int i = 0; i < 20; i++) tick("manual");
    end

    // Single-cycle illegal code on the 3-channel instance.
    control = 2'd3; tick("illegal");
    control = 2'd1; tick("legal_after");
    control = 2'd0; tick("back_to_0");

    // Scan from channel 0: full wrap of the 4-channel instance.
    mode = 1'b1;
    for (int i = 0; i < 13; i++) tick("scan");

    // Freeze mid-dwell, then resume.
    enable = 1'b0;
    for (int i = 0; i < 10; i++) tick("freeze");
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick("resume");

    // Asynchronous reset once the 4-channel instance sits on channel 2.
    budget = 0;
    while (m_sel[0] != 2 && budget < 40) begin tick("seek2"); budget++; end
    chk("reach_sel2", 32'(m_sel[0] == 2), 32'd1);
    async_reset("rst_mid");
    tick("rst_mid_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick("rescan");

    // Leave scan at channel 1 with counter 2, jump to channel 3, then rescan.
    budget = 0;
    while (!(m_sel[0] == 1 && m_cnt[0] == 2) && budget < 40) begin tick("seek1"); budget++; end
    chk("reach_sel1_cnt2", 32'(m_sel[0] == 1 && m_cnt[0] == 2), 32'd1);
    mode = 1'b0; control = 2'd3; tick("to_manual");
    mode = 1'b1; for (int i = 0; i < 5; i++) tick("from_manual");

    // Randomised phase: data, mode, control, enable and occasional async reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < 4; k++) data_a[k] = 4'($urandom);
        for (int k = 0; k < 3; k++) data_b[k] = 4'($urandom);
      end
      enable  = ($urandom_range(0, 9) != 0);
      control = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
        tick("rnd_rst_hold");
        rst_n = 1'b1;
      end else begin
        tick("random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muxn_scan.md
Name: muxn_scan

Overview:
Parametrised N-channel, W-bit registered multiplexer with two modes: manual select and automatic round-robin scan. It replaces the fixed 4:1 4-bit combinational mux wherever a datapath or display path needs a channel that is either selected directly or cycled through on its own. The output and the current selection are registered and always coherent with each other. Illegal select codes are flagged and never cause an out-of-range channel to be selected.

Parameters:
WIDTH, 4, data bits per channel (>=1)
CHANNELS, 4, number of input channels (2..256, need not be a power of 2)
SEL_W, 2, select width; must satisfy 2^SEL_W >= CHANNELS
DWELL, 20, clock cycles spent on each channel in scan mode (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_flat  input  CHANNELS*WIDTH  packed inputs; channel i = in_flat[i*WIDTH +: WIDTH]
mode  input  1  0 = manual, 1 = scan
control  input  SEL_W  manual channel select
enable  input  1  1 = block advances; 0 = all state frozen
out  output  WIDTH  registered selected data
cur_sel  output  SEL_W  channel that out currently reflects
sel_changed  output  1  one-cycle pulse when cur_sel changed on the last edge
sel_err  output  1  one-cycle pulse when manual control was >= CHANNELS

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately forces out=0, cur_sel=0, sel_changed=0, sel_err=0, dwell counter=0. Asserting reset mid-scan or mid-dwell abandons the dwell; no partial state survives.
- Internal state: cur_sel register, dwell counter (width clog2(DWELL), minimum 1 bit), and the out, sel_changed and sel_err registers.
- next_sel is computed combinationally. Every register updates at a rising edge only when enable=1.
- On each enabled edge: cur_sel<=next_sel and out<=in_flat[next_sel*WIDTH +: WIDTH]. out and cur_sel therefore always match; latency is one edge from sampled inputs to outputs.
- Input data changes on the selected channel appear on out after the next enabled edge, including while cur_sel is held.
- Manual mode (mode=0):
  - If control<CHANNELS: next_sel=control and sel_err<=0.
  - If control>=CHANNELS: next_sel=cur_sel (hold) and sel_err<=1.
  - The dwell counter is held at 0.
- Scan mode (mode=1), dwell counter:
  - If counter==DWELL-1: counter<=0 and next_sel=(cur_sel==CHANNELS-1)?0:cur_sel+1.
  - Otherwise: counter<=counter+1 and next_sel=cur_sel.
  - With DWELL=1, the channel advances on every enabled edge.
  - control is ignored and sel_err<=0.
- sel_changed<=(next_sel!=cur_sel) on each enabled edge.
- When enable=0:
  - out, cur_sel and the counter hold their values.
  - sel_changed and sel_err are forced to 0 on that edge, so the pulses stay single-cycle.
- Mode transitions:
  - manual to scan: scanning starts from the current cur_sel and the counter starts at 0. The first advance happens DWELL enabled edges after mode is sampled as 1.
  - scan to manual: the first edge with mode=0 takes control (if legal) and clears the counter.
- Simultaneous events: mode and control changing together are both sampled at the same edge. enable=0 has priority over every mode action. Reset has priority over everything.
- Wrap-around: with non-power-of-2 CHANNELS (e.g. 3 with SEL_W=2), scan order is 0,1,2,0; code 3 is never produced.

Test Plan:
- Reset and manual select: W=4, N=4, inputs 0101/0000/1111/0011. Release reset, then drive control 00,01,10,11,00 for 20 cycles each -> out=0101,0000,1111,0011,0101 one edge after each change; sel_changed pulses once per change; out=0 and cur_sel=0 while rst_n=0.
- Scan with DWELL=3: mode=1 from cur_sel=0 -> cur_sel sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; out tracks it; sel_changed pulses on edges 3,6,9,12.
- Non-power-of-2 and illegal select: N=3, SEL_W=2. Manual control=11 -> sel_err pulses one cycle and cur_sel/out hold. Scan -> 0,1,2,0 with no code 3.
- Freeze: enable=0 for 10 cycles in mid-dwell (counter=1) -> out, cur_sel and counter unchanged, no pulses. On re-enable the advance occurs after the remaining 2 edges (DWELL=3).
- Asynchronous reset mid-scan: assert rst_n=0 between clock edges at cur_sel=2 -> out=0 and cur_sel=0 immediately, without waiting for an edge. After release, scan restarts at channel 0 with a full dwell.
- Mode switch: scan at cur_sel=1, counter=2, then mode=0 with control=11 (N=4) -> cur_sel=3 and out=0011 next edge. Return to mode=1 -> stays on 3 for DWELL edges, then wraps to 0.
